// File: rtl/qc_ldpc_parity_enc.sv
// qc_ldpc_parity_enc
// Quasi-cyclic LDPC parity encoder. Information bits arrive serially in
// groups of Z. Each group fetches one generator row from an external ROM.
// Every '1' info bit XORs the current (progressively right-rotated) row into
// a Z-bit parity accumulator. After NGROUP groups the accumulator is
// serialised MSB-first over a valid/ready port, optionally through the
// differential chain p(i) ^= p(i-1).
//
// Frame flow: IDLE -> (FETCH -> ACCUM) x NGROUP -> DRAIN -> IDLE
//   FETCH : lasts ROM_LAT+1 cycles; one cycle for rom_addr to settle into the
//           ROM plus ROM_LAT cycles of read latency, then the row is latched.
//   ACCUM : din_ready high; one info bit per accept.
//   DRAIN : dout_valid high; one parity bit per transfer, idx Z-1 down to 0.

module qc_ldpc_parity_enc #(
  parameter int Z       = 360,  // circulant size / parity width
  parameter int NGROUP  = 12,   // info groups per codeword
  parameter int ROM_LAT = 1,    // ROM read latency in cycles (1..3)
  parameter int PAR_ACC = 1,    // 1 = differential-accumulated parity output
  parameter int AW      = 4     // ROM address width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [AW-1:0] rom_addr,
  input  logic [Z-1:0]  rom_data,
  output logic          dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  // Counter widths: bit/idx address one of Z positions, grp one of NGROUP
  // rows, fetch counts 0..ROM_LAT.
  localparam int CW = (Z > 1) ? $clog2(Z) : 1;
  localparam int GW = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam int FW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(Z - 1);
  localparam logic [GW-1:0] GRP_LAST   = GW'(NGROUP - 1);
  localparam logic [FW-1:0] FETCH_LAST = FW'(ROM_LAT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [FW-1:0] fetch_cnt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] idx;
  logic [GW-1:0] grp_cnt;
  logic [Z-1:0]  acc;
  logic [Z-1:0]  row;
  logic          prev_out;

  logic start_go;    // start honoured this cycle
  logic fetch_last;  // row is valid on rom_data this cycle
  logic accept;      // info bit consumed this cycle
  logic bit_last;    // current accept is the last bit of its group
  logic grp_last;    // current group is the final one
  logic xfer;        // parity bit handed downstream this cycle
  logic idx_zero;    // current parity bit is the final one

  // Handshake and status outputs, all decoded from registered state only.
  always_comb begin
    din_ready  = (state == S_ACCUM);
    dout_valid = (state == S_DRAIN);
    busy       = (state != S_IDLE);
    idx_zero   = (idx == '0);
    dout_last  = dout_valid && idx_zero;
    dout       = dout_valid && (acc[idx] ^ ((PAR_ACC != 0) ? prev_out : 1'b0));
  end

  // Event decodes shared by the register blocks below. A start that lands
  // on the done cycle is dropped; the caller must re-issue it in IDLE.
  always_comb begin
    start_go   = (state == S_IDLE) && start && !done;
    fetch_last = (state == S_FETCH) && (fetch_cnt == FETCH_LAST);
    accept     = din_valid && din_ready;
    bit_last   = (bit_cnt == BIT_LAST);
    grp_last   = (grp_cnt == GRP_LAST);
    xfer       = dout_valid && dout_ready;
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first so
    // that paths with no explicit assignment cannot infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_go)               state_nxt = S_FETCH;
      S_FETCH: if (fetch_last)             state_nxt = S_ACCUM;
      S_ACCUM: if (accept && bit_last)     state_nxt = grp_last ? S_DRAIN : S_FETCH;
      S_DRAIN: if (xfer && idx_zero)       state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  // State register; synchronous reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ROM latency counter: runs only while in FETCH, cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst)                               fetch_cnt <= '0;
    else if (state != S_FETCH || fetch_last) fetch_cnt <= '0;
    else                                   fetch_cnt <= fetch_cnt + FW'(1);
  end

  // Generator row: latched at the end of FETCH, rotated right once per
  // accepted info bit. bit_cnt tracks the position within the group.
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      bit_cnt <= '0;
    end else if (fetch_last) begin
      row     <= rom_data;
      bit_cnt <= '0;
    end else if (accept) begin
      row     <= {row[0], row[Z-1:1]};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // Parity accumulator: XORs the pre-rotation row on every '1' info bit;
  // cleared at frame start and after the last parity bit leaves.
  always_ff @(posedge clk) begin
    if (rst)                          acc <= '0;
    else if (start_go)                acc <= '0;
    else if (accept && din)           acc <= acc ^ row;
    else if (xfer && idx_zero)        acc <= '0;
  end

  // Group counter and ROM address: the address always equals the group
  // whose row the next FETCH will read.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_cnt  <= '0;
      rom_addr <= '0;
    end else if (start_go) begin
      grp_cnt  <= '0;
      rom_addr <= '0;
    end else if (accept && bit_last && !grp_last) begin
      grp_cnt  <= grp_cnt + GW'(1);
      rom_addr <= AW'(grp_cnt) + AW'(1);
    end
  end

  // Drain pointer and differential-chain memory. idx walks Z-1 down to 0;
  // prev_out remembers the last transferred bit for the p(i) ^= p(i-1) chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      prev_out <= 1'b0;
    end else if (accept && bit_last && grp_last) begin
      idx      <= BIT_LAST;
      prev_out <= 1'b0;
    end else if (xfer) begin
      prev_out <= dout;
      if (!idx_zero) idx <= idx - CW'(1);
    end
  end

  // One-cycle completion pulse following the final parity transfer.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= xfer && idx_zero;
  end

endmodule

// File: tb/tb_qc_ldpc_parity_enc.sv
// Self-checking bench for qc_ldpc_parity_enc (Z=8, NGROUP=2, ROM_LAT=2,
// PAR_ACC=1). Stimulus pushes the expected parity stream into a scoreboard
// queue; a monitor pops and compares on every dout transfer and also
// watches stall stability and the done pulse.

module tb_qc_ldpc_parity_enc;

  localparam int Z       = 8;
  localparam int NGROUP  = 2;
  localparam int ROM_LAT = 2;
  localparam int PAR_ACC = 1;
  localparam int AW      = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          din;
  logic          din_valid;
  logic          din_ready;
  logic [AW-1:0] rom_addr;
  logic [Z-1:0]  rom_data;
  logic          dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          done;

  qc_ldpc_parity_enc #(
    .Z(Z), .NGROUP(NGROUP), .ROM_LAT(ROM_LAT), .PAR_ACC(PAR_ACC), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: rows are read ROM_LAT cycles after the address is presented.
  logic [Z-1:0] rom_mem  [2**AW];
  logic [Z-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_mem[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t sb[$];
  logic     info_bits [NGROUP*Z];
  int       total;
  int       bad;
  int       rdy_mode;   // 0 always ready, 1 random, 2 fixed 4-cycle stall

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: parity = XOR over every '1' info bit of its group row
  // rotated right by the bit's position, emitted MSB first through the
  // optional differential chain.
  task automatic push_expected();
    logic [Z-1:0] a;
    logic [Z-1:0] r;
    logic         b;
    logic         prev;
    a = '0;
    for (int g = 0; g < NGROUP; g++)
      for (int k = 0; k < Z; k++)
        if (info_bits[g*Z+k]) begin
          r = rom_mem[g];
          a ^= (k == 0) ? r : ((r >> k) | (r << (Z - k)));
        end
    prev = 1'b0;
    for (int i = Z - 1; i >= 0; i--) begin
      b = a[i] ^ ((PAR_ACC != 0) ? prev : 1'b0);
      sb.push_back(exp_bit_t'{b, (i == 0)});
      prev = b;
    end
  endtask

  task automatic set_info_all(input logic v);
    for (int n = 0; n < NGROUP*Z; n++) info_bits[n] = v;
  endtask

  // Downstream ready generator.
  initial begin
    int drain_cyc;
    drain_cyc  = 0;
    dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: dout_ready = 1'b1;
        1: dout_ready = 1'($urandom_range(0, 1));
        default: begin
          drain_cyc  = dout_valid ? drain_cyc + 1 : 0;
          dout_ready = !(drain_cyc >= 3 && drain_cyc <= 6);
        end
      endcase
    end
  end

  // Monitor: scoreboard compare, stall stability and done timing.
  initial begin
    exp_bit_t e;
    logic     stalled;
    logic     exp_done;
    logic     h_dout;
    logic     h_last;
    stalled  = 1'b0;
    exp_done = 1'b0;
    h_dout   = 1'b0;
    h_last   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled  = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (exp_done || done) check("done_pulse", done, exp_done);
        if (stalled) begin
          check("stall_valid", dout_valid, 1);
          check("stall_dout", dout, h_dout);
          check("stall_last", dout_last, h_last);
        end
        exp_done = 1'b0;
        stalled  = 1'b0;
        if (dout_valid && dout_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_dout", 1, 0);
          end else begin
            e = sb.pop_front();
            check("dout", dout, e.b);
            check("dout_last", dout_last, e.last);
            exp_done = e.last;
          end
        end else if (dout_valid) begin
          stalled = 1'b1;
          h_dout  = dout;
          h_last  = dout_last;
        end
      end
    end
  end

  // One frame. vmode: 0 constant din_valid, 1 toggling, 2 random.
  // abort_at >= 0 asserts rst once that many bits have been accepted.
  task automatic run_frame(input int vmode, input int abort_at,
                           input bit busy_start, input bit start_on_done);
    int n;
    int guard;
    int cnt;
    bit acc_now;
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cnt = 0;
    while (!din_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("first_ready_latency", cnt, ROM_LAT + 1);

    n = 0;
    guard = 0;
    while (n < NGROUP*Z && guard < 2000) begin
      if (abort_at >= 0 && n == abort_at) begin
        din_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("abort_busy", busy, 0);
        check("abort_din_ready", din_ready, 0);
        check("abort_dout_valid", dout_valid, 0);
        return;
      end
      din       = info_bits[n];
      din_valid = (vmode == 0) ? 1'b1 :
                  (vmode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
      start     = busy_start && (n == 3);
      acc_now   = din_valid && din_ready;
      @(posedge clk); #1;
      guard++;
      start = 1'b0;
      if (acc_now) begin
        n++;
        if (n % Z == 0 && n < NGROUP*Z) begin
          // Junk presented during the fetch gap must be ignored.
          din       = 1'b1;
          din_valid = 1'b1;
          cnt = 0;
          while (!din_ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
          end
          check("group_gap", cnt, ROM_LAT + 1);
        end
      end
    end
    din_valid = 1'b0;
    check("valid_after_last_accept", dout_valid, 1);

    guard = 0;
    while (!done && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done_seen", done, 1);
    if (start_on_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after_done", busy, 0);
    check("no_restart", din_ready, 0);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  // Watchdog: the run is bounded everywhere, this is a last resort.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    rdy_mode  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_din_ready", din_ready, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ignores_din", din_ready, 0);
    din_valid = 1'b0;

    // All-ones info over a single-bit row: every accumulator bit set once.
    rom_mem[0] = 8'h01; rom_mem[1] = 8'h00;
    set_info_all(1'b1);
    run_frame(0, -1, 0, 0);

    // Single info bit at position 1 and position 0.
    set_info_all(1'b0); info_bits[1] = 1'b1;
    run_frame(0, -1, 0, 0);
    set_info_all(1'b0); info_bits[0] = 1'b1;
    run_frame(0, -1, 0, 0);

    // Two groups, second row 8'h03, din_valid toggling.
    rom_mem[0] = 8'h01; rom_mem[1] = 8'h03;
    set_info_all(1'b1);
    run_frame(1, -1, 0, 0);

    // Mid-stream 4-cycle downstream stall.
    rdy_mode = 2;
    rom_mem[1] = 8'h00;
    run_frame(0, -1, 0, 0);
    rdy_mode = 0;

    // Reset in ACCUM of group 1, then a fresh frame with a start while busy
    // and a start on the done cycle (both must be ignored).
    run_frame(0, Z + 3, 1, 0);
    run_frame(0, -1, 1, 1);

    // Randomised frames.
    rdy_mode = 1;
    for (int f = 0; f < 12; f++) begin
      for (int g = 0; g < NGROUP; g++) rom_mem[g] = Z'($urandom);
      for (int n = 0; n < NGROUP*Z; n++) info_bits[n] = 1'($urandom_range(0, 1));
      run_frame(2, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
